// File: rtl/weight_pkg.sv
// Shared constants, types and LFSR step function for the weight initialiser.
// Network shape: 30 inputs x 5 hidden + 5 hidden x 3 outputs = 165 weights.
package weight_pkg;

  localparam int N_IN        = 30;
  localparam int N_HID       = 5;
  localparam int N_OUT       = 3;
  localparam int NUM_WEIGHTS = N_IN * N_HID + N_HID * N_OUT;
  localparam int WIDTH       = 10;
  localparam int ADDR_W      = 8;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic signed [WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY,
    DONE
  } state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/weight_init_seq_if.sv
// Write/read port of the weight RAM. The sequencer is the master; the RAM is
// the slave and returns Q one cycle after Address is presented.
interface weight_init_seq_if #(
  parameter int WIDTH  = weight_pkg::WIDTH,
  parameter int ADDR_W = weight_pkg::ADDR_W
);

  logic signed [WIDTH-1:0] D;
  logic [ADDR_W-1:0]       Address;
  logic                    WE;
  logic signed [WIDTH-1:0] Q;

  modport master (output D, output Address, output WE, input Q);
  modport slave  (input D, input Address, input WE, output Q);

endinterface

// File: rtl/weight_lfsr.sv
// 16-bit Galois LFSR with seed on reset, parallel load and step enable.
// Used once for weight generation and, with readback enabled, as the replay copy.
module weight_lfsr
  import weight_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  // Load has priority over step; only Rst restores the seed.
  always_ff @(posedge Clock or posedge Rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (Rst)       state <= SEED;
    else if (load) state <= load_val;
    else if (step) state <= lfsr_next(state);
  end

endmodule

// File: rtl/weight_init_seq.sv
// Weight RAM initialiser: on Start, writes NUM_WEIGHTS pseudo-random signed
// weights to consecutive addresses, one per clock.
// Optional macro WEIGHT_READBACK_EN adds a VERIFY pass that reads every entry
// back and raises a sticky Error on any mismatch.
module weight_init_seq #(
  parameter int          NUM_WEIGHTS = weight_pkg::NUM_WEIGHTS,
  parameter int          WIDTH       = weight_pkg::WIDTH,
  parameter int          ADDR_W      = weight_pkg::ADDR_W,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SCALE_SHIFT = 2
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              Start,
  weight_init_seq_if.master ram,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  import weight_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic signed [WIDTH-1:0] d_q;
  logic [15:0]             lfsr_q;
  logic                    accept;
  logic                    wr_step;
  logic                    last_addr;
  logic signed [WIDTH-1:0] raw_w;
  logic signed [WIDTH-1:0] weight;

  assign raw_w     = lfsr_q[WIDTH-1:0];
  assign weight    = raw_w >>> SCALE_SHIFT;
  assign last_addr = (addr_q == LAST_ADDR);

  weight_lfsr #(.SEED(SEED)) u_lfsr (
    .Clock    (Clock),
    .Rst      (Rst),
    .load     (1'b0),
    .load_val (16'h0000),
    .step     (wr_step),
    .state    (lfsr_q)
  );

`ifdef WEIGHT_READBACK_EN
  logic [15:0]             replay_q;
  logic signed [WIDTH-1:0] replay_raw;
  logic signed [WIDTH-1:0] replay_w;
  logic signed [WIDTH-1:0] exp_q;
  logic                    v_step;
  logic                    tail_q;
  logic                    cmp_vld_q;
  logic                    err_q;

  assign replay_raw = replay_q[WIDTH-1:0];
  assign replay_w   = replay_raw >>> SCALE_SHIFT;

  // Snapshot of the generator taken at Start, replayed during VERIFY.
  weight_lfsr #(.SEED(SEED)) u_replay (
    .Clock    (Clock),
    .Rst      (Rst),
    .load     (accept),
    .load_val (lfsr_q),
    .step     (v_step),
    .state    (replay_q)
  );
`endif

  // State register.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    accept  = 1'b0;
    wr_step = 1'b0;
    ram.WE  = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
`ifdef WEIGHT_READBACK_EN
    v_step  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          wr_step = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram.WE = 1'b1;
        Busy   = 1'b1;
        if (last_addr) begin
`ifdef WEIGHT_READBACK_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end else begin
          wr_step = 1'b1;
        end
      end
      VERIFY: begin
`ifdef WEIGHT_READBACK_EN
        Busy   = 1'b1;
        v_step = !tail_q;
        if (tail_q) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          accept  = 1'b1;
          wr_step = 1'b1;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counter and weight register; both hold outside active phases.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      addr_q <= '0;
      d_q    <= '0;
    end else if (accept) begin
      addr_q <= '0;
      d_q    <= weight;
    end else if (state_q == WRITE) begin
      if (!last_addr) begin
        addr_q <= addr_q + ADDR_W'(1);
        d_q    <= weight;
      end
`ifdef WEIGHT_READBACK_EN
      else begin
        addr_q <= '0;
      end
    end else if (state_q == VERIFY && !tail_q && !last_addr) begin
      addr_q <= addr_q + ADDR_W'(1);
`endif
    end
  end

  assign ram.D       = d_q;
  assign ram.Address = addr_q;

`ifdef WEIGHT_READBACK_EN
  // Readback compare: Q for address k arrives the cycle after Address=k,
  // so the expected weight is staged one cycle in exp_q.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      exp_q     <= '0;
      tail_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      tail_q    <= 1'b0;
      cmp_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (state_q == VERIFY) begin
      if (cmp_vld_q && (ram.Q != exp_q)) err_q <= 1'b1;
      if (!tail_q) begin
        exp_q     <= replay_w;
        cmp_vld_q <= 1'b1;
        if (last_addr) tail_q <= 1'b1;
      end
    end
  end

  assign Error = err_q;
`else
  logic unused_q;
  assign unused_q = ^ram.Q;
  assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_weight_init_seq.sv
// Self-checking bench for weight_init_seq: two instances (SCALE_SHIFT 2 and 0)
// each with a behavioural RAM, checked every cycle against a timeline model.
`timescale 1ns/1ps
module tb_weight_init_seq;

  localparam int N = 165;
`ifdef WEIGHT_READBACK_EN
  localparam int END_T = 2 * N + 2;
`else
  localparam int END_T = N + 1;
`endif

  logic Clock = 1'b0;
  logic Rst   = 1'b1;
  logic Start = 1'b0;
  logic busy_a, done_a, error_a;
  logic busy_b, done_b, error_b;

  always #5 Clock = ~Clock;

  weight_init_seq_if ram_a ();
  weight_init_seq_if ram_b ();

  weight_init_seq #(.SCALE_SHIFT(2)) dut_a (
    .Clock (Clock), .Rst (Rst), .Start (Start), .ram (ram_a),
    .Busy (busy_a), .Done (done_a), .Error (error_a)
  );

  weight_init_seq #(.SCALE_SHIFT(0)) dut_b (
    .Clock (Clock), .Rst (Rst), .Start (Start), .ram (ram_b),
    .Busy (busy_b), .Done (done_b), .Error (error_b)
  );

  // Behavioural RAMs, synchronous read; entry 17 of RAM a can be corrupted.
  logic signed [9:0] mem_a [256];
  logic signed [9:0] mem_b [256];
  bit corrupt_a = 1'b0;

  always @(posedge Clock) begin
    if (ram_a.WE)
      mem_a[ram_a.Address] <= (corrupt_a && ram_a.Address == 8'd17) ? (ram_a.D ^ 10'b1) : ram_a.D;
    ram_a.Q <= mem_a[ram_a.Address];
    if (ram_b.WE) mem_b[ram_b.Address] <= ram_b.D;
    ram_b.Q <= mem_b[ram_b.Address];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] step16(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int wgt(input logic [15:0] l, input int sh);
    logic signed [9:0] r;
    r = l[9:0];
    return int'(r) >>> sh;
  endfunction

  logic [15:0] mdl_l = 16'hACE1;   // generator value for the next run
  logic [15:0] run_l [N];          // generator values of the current run
  int          run_t = 0;          // cycle number within the run, 0 = none
  bit          exp_err_a = 1'b0;
  bit          start_smp = 1'b0;

  always @(posedge Clock) start_smp <= Start && !Rst;

  task automatic check_dut(input string tag, input int sh, input logic we,
                           input logic [7:0] addr, input logic signed [9:0] d,
                           input logic busy, input logic done, input logic err,
                           input logic e_err);
    int t, e_addr, e_d;
    bit e_we, e_busy, e_done, chk_err, e_errv;
    t = run_t;
    e_we = 0; e_addr = 0; e_d = 0; e_busy = 0; e_done = 0; chk_err = 1; e_errv = 0;
    if (t >= 1 && t <= N) begin
      e_we = 1; e_addr = t - 1; e_d = wgt(run_l[t-1], sh); e_busy = 1;
    end else if (t > N && t < END_T) begin
      e_addr = (t - N - 1 > N - 1) ? N - 1 : t - N - 1;
      e_d = wgt(run_l[N-1], sh); e_busy = 1; chk_err = 0;
    end else if (t >= END_T) begin
      e_addr = N - 1; e_d = wgt(run_l[N-1], sh); e_done = 1; e_errv = e_err;
    end
    check({tag, ".WE"}, int'(we), int'(e_we));
    check({tag, ".Address"}, int'(addr), e_addr);
    check({tag, ".D"}, int'(d), e_d);
    check({tag, ".Busy"}, int'(busy), int'(e_busy));
    check({tag, ".Done"}, int'(done), int'(e_done));
    if (chk_err) check({tag, ".Error"}, int'(err), int'(e_errv));
  endtask

  // Advance the model for the edge just taken, then compare both DUTs.
  always @(negedge Clock) begin
    int prev;
    if (Rst) begin
      run_t     = 0;
      mdl_l     = 16'hACE1;
      exp_err_a = 1'b0;
    end else begin
      prev = run_t;
      if (start_smp && (prev == 0 || prev >= END_T)) begin
        for (int i = 0; i < N; i++) begin
          run_l[i] = mdl_l;
          mdl_l    = step16(mdl_l);
        end
        run_t     = 1;
        exp_err_a = corrupt_a;
      end else if (prev > 0 && prev < END_T) begin
        run_t = prev + 1;
      end
    end
    check_dut("a", 2, ram_a.WE, ram_a.Address, ram_a.D, busy_a, done_a, error_a, exp_err_a);
    check_dut("b", 0, ram_b.WE, ram_b.Address, ram_b.D, busy_b, done_b, error_b, 1'b0);
  end

  // Write log of instance a, indexed by address.
  int cur_seq [N];
  int we_cnt = 0;
  always @(negedge Clock) begin
    if (!Rst && ram_a.WE) begin
      we_cnt <= we_cnt + 1;
      if (int'(ram_a.Address) < N) cur_seq[ram_a.Address] <= int'(ram_a.D);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(posedge Clock); #1 Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int dcyc);
    ok = 1'b0; dcyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge Clock); #1;
      if (done_a) begin ok = 1'b1; dcyc = cyc; break; end
    end
  endtask

  int run1_seq [N];
  int c0, dcyc, we_base, ndiff;
  bit ok;

  initial begin
    repeat (3) @(posedge Clock);
    #1 Rst = 1'b0;
    check("reset.Busy", int'(busy_a), 0);
    check("reset.Done", int'(done_a), 0);
    check("reset.D", int'(ram_a.D), 0);

    // Run 1, with a Start pulse in the middle that must be ignored.
    we_base = we_cnt;
    pulse_start();
    c0 = cyc;
    check("run1.c1.WE", int'(ram_a.WE), 1);
    check("run1.c1.Address", int'(ram_a.Address), 0);
    check("run1.c1.D", int'(ram_a.D), 56);
    check("run1.c1.D_shift0", int'(ram_b.D), 225);
    @(posedge Clock); #1;
    check("run1.c2.Address", int'(ram_a.Address), 1);
    check("run1.c2.D", int'(ram_a.D), -100);
    check("run1.c2.D_shift0", int'(ram_b.D), -400);
    repeat (46) @(posedge Clock);
    pulse_start();
    wait_done(ok, dcyc);
    check("run1.done_seen", int'(ok), 1);
    check("run1.done_cycle", dcyc - c0 + 1, END_T);
    check("run1.we_count", we_cnt - we_base, N);
    run1_seq = cur_seq;
    repeat (5) @(posedge Clock);
    #1;
    check("run1.idle.Done", int'(done_a), 1);
    check("run1.idle.WE", int'(ram_a.WE), 0);

    // Run 2: generator continues, so the weight set differs.
    pulse_start();
    wait_done(ok, dcyc);
    check("run2.done_seen", int'(ok), 1);
    ndiff = 0;
    for (int i = 0; i < N; i++) if (cur_seq[i] != run1_seq[i]) ndiff++;
    check("run2.differs_from_run1", int'(ndiff > 0), 1);

    // Run 3: asynchronous reset at Address 80.
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clock); #1;
      if (ram_a.WE && ram_a.Address == 8'd80) begin ok = 1'b1; break; end
    end
    check("run3.reached_addr80", int'(ok), 1);
    #1 Rst = 1'b1;
    #1;
    check("rst_async.WE", int'(ram_a.WE), 0);
    check("rst_async.Address", int'(ram_a.Address), 0);
    check("rst_async.D", int'(ram_a.D), 0);
    check("rst_async.Busy", int'(busy_a), 0);
    check("rst_async.Done", int'(done_a), 0);
    check("rst_async.Error", int'(error_a), 0);
    check("rst_async.D_shift0", int'(ram_b.D), 0);
    @(posedge Clock);
    @(posedge Clock); #1 Rst = 1'b0;

    // Run 4: reseeded, must reproduce run 1 exactly.
    pulse_start();
    check("run4.c1.D", int'(ram_a.D), 56);
    check("run4.c1.D_shift0", int'(ram_b.D), 225);
    wait_done(ok, dcyc);
    check("run4.done_seen", int'(ok), 1);
    ndiff = 0;
    for (int i = 0; i < N; i++) if (cur_seq[i] != run1_seq[i]) ndiff++;
    check("run4.same_as_run1", ndiff, 0);
    check("run4.Error", int'(error_a), 0);

`ifdef WEIGHT_READBACK_EN
    // Run 5: corrupted entry 17 in RAM a must be flagged.
    corrupt_a = 1'b1;
    pulse_start();
    wait_done(ok, dcyc);
    check("run5.done_seen", int'(ok), 1);
    check("run5.Error_a", int'(error_a), 1);
    check("run5.Error_b", int'(error_b), 0);
    corrupt_a = 1'b0;
`endif

    repeat (3) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_init_seq.md
Name: weight_init_seq

Overview:
Sequencer that fills the 165-entry signed 10-bit weight RAM with pseudo-random initial weights before training or inference begins. Layout is 150 input→hidden weights (30×5) followed by 15 hidden→output weights (5×3). On a Start pulse it steps an internal LFSR once per entry, scales each value, and writes one weight per clock through the RAM's D/Address/WE interface. It sits directly upstream of the weight RAM and owns its write port during initialisation.

Parameters:
NUM_WEIGHTS, 165, number of RAM entries written (addresses 0..NUM_WEIGHTS-1)
WIDTH, 10, weight width (signed, two's complement)
ADDR_W, 8, RAM address width
SEED, 16'hACE1, LFSR reset value (must be non-zero)
SCALE_SHIFT, 2, arithmetic right shift applied to the raw weight (0..WIDTH-1)

Ports:
Clock  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
Start  in  1  single-cycle request to begin an initialisation run
D  out  WIDTH  signed weight to RAM
Address  out  ADDR_W  RAM address
WE  out  1  1 = write D to Address, 0 = read
Q  in  WIDTH  RAM read data (used only with the optional feature)
Busy  out  1  high while a run is in progress
Done  out  1  high from run completion until the next accepted Start
Error  out  1  readback mismatch flag (optional feature, else tied 0)

Behaviour:
- Reset (Rst=1, async): D=0, Address=0, WE=0, Busy=0, Done=0, Error=0, LFSR=SEED, state=IDLE. Rst asserted mid-run aborts immediately. RAM contents are left partially written and no Done is given.
- LFSR: 16-bit Galois, right-shifting, mask 16'hB400. Next = (L>>1) ^ (L[0] ? 16'hB400 : 0). Steps exactly once per written weight. It is reseeded only by Rst, so consecutive runs produce different weight sets.
- Weight = $signed(L[9:0]) >>> SCALE_SHIFT, computed from the current L before stepping.
- States:
  - IDLE: Start=1 → WRITE; Busy=1 and Done=0 next cycle.
  - WRITE: WE=1, Address=k, D=weight(k), with k counting 0..NUM_WEIGHTS-1, one per cycle and no gaps. After k=NUM_WEIGHTS-1 → DONE (or VERIFY if the feature is on).
  - DONE: WE=0, Busy=0, Done=1. Start=1 → WRITE with k=0.
- Latency: Start sampled at edge 0 → first write (Address=0) at cycle 1. Last write (Address=164) at cycle 165. Done=1 from cycle 166.
- Start while Busy=1 is ignored.
- Address never exceeds NUM_WEIGHTS-1. The counter does not wrap during a run.
- Outside WRITE, WE=0 and Address holds its last value. D holds its last value.

Optional Feature:
- Macro WEIGHT_READBACK_EN.
- Defined:
  - At the first accepted Start, snapshot L into a replay register. After WRITE, enter VERIFY.
  - VERIFY drives WE=0 and Address k=0..NUM_WEIGHTS-1 one per cycle.
  - Q for address k is compared in the following cycle against the replayed weight(k).
  - Any mismatch sets Error=1 (sticky until Rst or next accepted Start).
  - VERIFY lasts NUM_WEIGHTS+1 cycles, then → DONE. Done rises at cycle 332.
- Undefined: no VERIFY state and no replay register; Q is unused; Error is constant 0.

Decomposition:
- Shared package weight_pkg:
  - constants NUM_WEIGHTS=165, N_IN=30, N_HID=5, N_OUT=3, WIDTH=10, ADDR_W=8, LFSR_MASK=16'hB400
  - typedef weight_t (logic signed [9:0])
  - typedef state enum {IDLE, WRITE, VERIFY, DONE}
- One sub-module: weight_lfsr (seed load, step enable, 16-bit state out). It is reused for the replay copy under WEIGHT_READBACK_EN.

Test Plan:
- Reset then Start, SEED=ACE1, SCALE_SHIFT=2:
  - cycle 1: WE=1, Address=0, D=56 (0x0E1=225>>>2)
  - cycle 2: Address=1, D=-100 (L=E270, 0x270=-400>>>2)
- Full run: exactly 165 WE pulses on addresses 0..164 in order, each once. Busy high for cycles 1..165. Done=1 at cycle 166, WE=0 thereafter.
- Start pulsed at cycle 50 of a run → ignored; count stays 165 writes. Second Start after Done → new run with a different first weight (LFSR continues).
- Rst asserted at Address=80 → all outputs 0 asynchronously. Next Start reproduces the first run's sequence (D=56 first).
- WEIGHT_READBACK_EN with a behavioural RAM model: Error=0, Done at cycle 332. Corrupt entry 17 in the model → Error=1 at Done.
- SCALE_SHIFT=0: raw 0x270 → D=-400. Check sign extension holds for all 165 values (range -512..511).
